rs232_rx_framed: RTL and testbench
==================================

RS232_RX_FRAMED -- requirements
Module: rs232_rx_framed

Interface
REQ-001 Parameter CLOCK_FREQ, real, default 133000000 -- clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, real, default 115200 -- line bit rate in bit/s.
REQ-003 Parameter DATA_BITS, integer, default 8 -- data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, integer, default 0 -- parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, integer, default 1 -- stop bits per frame; legal values 1 or 2.
REQ-006 Port clock, input, 1 -- the single clock; all logic on its rising edge.
REQ-007 Port resetn, input, 1 -- reset, asynchronous and active-low.
REQ-008 Port rxd_pin, input, 1 -- serial data, connected to the transmitter TXD pin; idle high.
REQ-009 Port rtsn_pin, output, 1 -- flow control, connected to the transmitter CTSn pin; 1 = stop sending.
REQ-010 Port odata, output, DATA_BITS -- received word, LSB first on the line.
REQ-011 Port operror, output, 1 -- the parity bit of the beat was wrong; always 0 when PARITY=0.
REQ-012 Port oframe, output, 1 -- a stop bit of the beat was sampled 0.
REQ-013 Port ovalid, output, 1 -- AXI-stream valid for odata, operror and oframe.
REQ-014 Port oready, input, 1 -- AXI-stream ready.
REQ-015 Port overflow, output, 1 -- sticky flag: a frame was lost.

Function
REQ-016 Elaboration SHALL fail if a parameter is out of its legal range, or if BAUD_COUNT = round(CLOCK_FREQ/BAUD_RATE) is less than 8.
REQ-017 rxd_pin SHALL pass through a two-flop synchroniser (reset value 1) and then a 3-bit history shift register (reset value 111); the bit value used is the majority of the 3-bit history.
REQ-018 States: IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-019 IDLE -> START SHALL occur only on a falling edge: the majority value is 0 and was 1 in the previous cycle; a line held low never retriggers.
REQ-020 On entering START, the baud counter SHALL load so the first sample falls at floor(BAUD_COUNT/2) clocks; every later sample falls BAUD_COUNT clocks after the previous one.
REQ-021 START sample = 1 SHALL be treated as a false start: return to IDLE, no output beat.
REQ-022 DATA SHALL shift DATA_BITS samples LSB-first into the shift register, then go to PARITY or STOP.
REQ-023 PARITY sample SHALL set the parity error bit when the XOR of the data bits and the parity sample is 0 for odd parity, or 1 for even parity.
REQ-024 STOP SHALL take STOP_BITS samples; any 0 sample sets the frame error bit.
REQ-025 At the last stop sample the FSM SHALL return to IDLE in the same cycle, with no wait for the end of the stop bit.
REQ-026 The frame SHALL complete at that last stop sample; odata, operror, oframe and ovalid=1 are loaded on the next clock edge (1-cycle latency).
REQ-027 The output register holds one beat; it SHALL stay stable while ovalid && !oready and clear ovalid on ovalid && oready.
REQ-028 A frame completing while ovalid && !oready SHALL be dropped, set overflow (cleared only by reset) and leave the held beat unchanged.
REQ-029 A frame completing in the same cycle as an ovalid && oready transfer SHALL be accepted as the next beat, with no overflow.
REQ-030 rtsn_pin SHALL register ovalid and update only while in IDLE, so it never changes mid-frame.
REQ-031 Break condition (line low for a whole frame) SHALL produce exactly one beat with odata=0 and oframe=1; no further beats until the line returns high.

Reset
REQ-032 When resetn=0, at any time including mid-frame: state IDLE, ovalid=0, operror=0, oframe=0, overflow=0, rtsn_pin=1, synchroniser and history = all ones.
REQ-033 odata has no reset value.
REQ-034 After resetn rises, rtsn_pin SHALL drop to 0 on the first IDLE cycle.
REQ-035 A frame cut by reset SHALL produce no beat.
REQ-036 Deassertion of reset SHALL be treated as synchronous to clock by the integrator.

Verification (CLOCK_FREQ=1843200, BAUD_RATE=115200, BAUD_COUNT=16)
REQ-037 DATA_BITS=8, PARITY=0: send 0xA5, oready=1 -> one beat odata=0xA5, operror=0, oframe=0; ovalid rises 1 clock after the stop-bit midpoint.
REQ-038 PARITY=2: send 0x37 with parity bit 1 -> operror=0; send 0x37 with parity bit 0 -> operror=1, odata=0x37.
REQ-039 3-clock low glitch on an idle line -> no beat; a valid 0x55 sent afterwards is received correctly.
REQ-040 Line low for 20 bit times, then high -> exactly one beat odata=0, oframe=1; then 0x0F is received normally.
REQ-041 oready=0, send 0x11 then 0x22 -> held beat is 0x11, overflow=1, rtsn_pin=1 after the first frame; with oready=1 and 0x22 sent in the transfer cycle -> no overflow.
REQ-042 Assert resetn=0 in the middle of data bit 4 -> no beat, all outputs at reset values; the next frame 0xC3 is received correctly.

Source files
------------

// File: rtl/rs232_rx_framed.sv
// RS-232 receiver with framing/parity checks, a one-beat AXI-stream output
// register, sticky overflow and an RTS flow-control output.
module rs232_rx_framed #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  DATA_BITS  = 8,
    parameter int  PARITY     = 0,
    parameter int  STOP_BITS  = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 rxd_pin,
    output logic                 rtsn_pin,
    output logic [DATA_BITS-1:0] odata,
    output logic                 operror,
    output logic                 oframe,
    output logic                 ovalid,
    input  logic                 oready,
    output logic                 overflow
);

    localparam int BAUD_COUNT = int'(CLOCK_FREQ / BAUD_RATE);
    localparam int CW         = $clog2(BAUD_COUNT);

    localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_COUNT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_COUNT / 2 - 1);
    localparam logic [3:0]    LAST_DATA   = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP   = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("rs232_rx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("rs232_rx_framed: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("rs232_rx_framed: STOP_BITS must be 1 or 2");
    end
    if (BAUD_COUNT < 8) begin : g_bad_baud
        $error("rs232_rx_framed: CLOCK_FREQ/BAUD_RATE must round to at least 8");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             sync_q;
    logic [2:0]             hist_q;
    logic                   maj;
    logic                   maj_q;
    logic [CW-1:0]          baud_q, baud_d;
    logic [3:0]             bit_q, bit_d;
    logic                   stop_q, stop_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   sample;
    logic                   frame_done;
    logic                   load_beat;

    assign maj = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

    // Input synchroniser, 3-sample history and previous majority for edge detect
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
            hist_q <= '1;
            maj_q  <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], rxd_pin};
            hist_q <= {hist_q[1:0], sync_q[1]};
            maj_q  <= maj;
        end
    end

    // Frame FSM and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            sh_q    <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            sh_q    <= sh_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: sample point at baud counter zero, frame completes at last stop sample
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        sh_d       = sh_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        frame_done = 1'b0;
        sample     = (baud_q == '0);

        if (state_q != S_IDLE) begin
            baud_d = sample ? BAUD_RELOAD : baud_q - CW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (!maj && maj_q) begin
                    state_d = S_START;
                    baud_d  = HALF_RELOAD;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            S_START: begin
                if (sample) begin
                    state_d = maj ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (sample) begin
                    sh_d  = {maj, sh_q[DATA_BITS-1:1]};
                    bit_d = bit_q + 4'd1;
                    if (bit_q == LAST_DATA) begin
                        state_d = (PARITY == 0) ? S_STOP : S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_d  = (PARITY == 1) ? ~(^sh_q ^ maj) : (^sh_q ^ maj);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    ferr_d = ferr_q | ~maj;
                    stop_d = stop_q + 1'b1;
                    if (stop_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A completed frame is taken when the register is empty or draining this cycle
    assign load_beat = frame_done && (!ovalid || oready);

    // Output beat flags and sticky overflow
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovalid   <= 1'b0;
            operror  <= 1'b0;
            oframe   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (ovalid && oready) begin
                ovalid <= 1'b0;
            end
            if (load_beat) begin
                ovalid  <= 1'b1;
                operror <= perr_q;
                oframe  <= ferr_d;
            end else if (frame_done) begin
                overflow <= 1'b1;
            end
        end
    end

    // Output data word, deliberately without reset
    always_ff @(posedge clock) begin
        if (load_beat) begin
            odata <= sh_q;
        end
    end

    // Flow control follows ovalid but only between frames
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rtsn_pin <= 1'b1;
        end else if (state_q == S_IDLE) begin
            rtsn_pin <= ovalid;
        end
    end

endmodule

// File: tb/tb_rs232_rx_framed.sv
// Directed self-checking bench for rs232_rx_framed at 16 clocks per bit.
module tb_rs232_rx_framed;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       rxd = 1'b1;
    logic       rxd2 = 1'b1;
    logic       oready = 1'b1;
    logic       oready2 = 1'b1;

    logic       rtsn_pin, operror, oframe, ovalid, overflow;
    logic [7:0] odata;
    logic       rtsn_pin2, operror2, oframe2, ovalid2, overflow2;
    logic [7:0] odata2;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // 8N1 receiver
    rs232_rx_framed #(
        .CLOCK_FREQ(1843200.0),
        .BAUD_RATE (115200.0),
        .DATA_BITS (8),
        .PARITY    (0),
        .STOP_BITS (1)
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .rxd_pin (rxd),
        .rtsn_pin(rtsn_pin),
        .odata   (odata),
        .operror (operror),
        .oframe  (oframe),
        .ovalid  (ovalid),
        .oready  (oready),
        .overflow(overflow)
    );

    // 8E1 receiver
    rs232_rx_framed #(
        .CLOCK_FREQ(1843200.0),
        .BAUD_RATE (115200.0),
        .DATA_BITS (8),
        .PARITY    (2),
        .STOP_BITS (1)
    ) dut_even (
        .clock   (clock),
        .resetn  (resetn),
        .rxd_pin (rxd2),
        .rtsn_pin(rtsn_pin2),
        .odata   (odata2),
        .operror (operror2),
        .oframe  (oframe2),
        .ovalid  (ovalid2),
        .oready  (oready2),
        .overflow(overflow2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Beat logs: {oframe, operror, odata} of every accepted transfer
    logic [9:0] log1 [64];
    logic [9:0] log2 [64];
    int beats1 = 0;
    int beats2 = 0;
    int rise1  = -1;
    logic vprev1 = 1'b0;

    always @(negedge clock) begin
        if (ovalid && oready) begin
            log1[beats1 % 64] = {oframe, operror, odata};
            beats1 = beats1 + 1;
        end
        if (ovalid && !vprev1) rise1 = cyc;
        vprev1 = ovalid;
        if (ovalid2 && oready2) begin
            log2[beats2 % 64] = {oframe2, operror2, odata2};
            beats2 = beats2 + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v, input bit sel);
        if (sel) rxd2 = v;
        else     rxd  = v;
        tick(16);
    endtask

    task automatic send(input logic [8:0] bits, input int nbits, input bit sel);
        drive_bit(1'b0, sel);
        for (int i = 0; i < nbits; i++) drive_bit(bits[i], sel);
        drive_bit(1'b1, sel);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        tick(3);
        total++; if (ovalid !== 1'b0)   $display("FAIL reset_ovalid got %b exp 0", ovalid);     else passed++;
        total++; if (operror !== 1'b0)  $display("FAIL reset_operror got %b exp 0", operror);   else passed++;
        total++; if (oframe !== 1'b0)   $display("FAIL reset_oframe got %b exp 0", oframe);     else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passed++;
        total++; if (rtsn_pin !== 1'b1) $display("FAIL reset_rtsn got %b exp 1", rtsn_pin);     else passed++;
        resetn = 1'b1;
        tick(2);
        total++; if (rtsn_pin !== 1'b0)  $display("FAIL reset_rtsn_release got %b exp 0", rtsn_pin);   else passed++;
        total++; if (rtsn_pin2 !== 1'b0) $display("FAIL reset_rtsn2_release got %b exp 0", rtsn_pin2); else passed++;
    endtask

    task automatic test_basic;
        int b0, s;
        logic [9:0] e;
        oready = 1'b1;
        b0 = beats1;
        s  = cyc;
        send({1'b0, 8'hA5}, 8, 1'b0);
        tick(20);
        e = log1[b0 % 64];
        total++; if (beats1 - b0 !== 1) $display("FAIL basic_beats got %0d exp 1", beats1 - b0); else passed++;
        total++; if (e[7:0] !== 8'hA5)  $display("FAIL basic_data got %h exp a5", e[7:0]);      else passed++;
        total++; if (e[8] !== 1'b0)     $display("FAIL basic_operror got %b exp 0", e[8]);       else passed++;
        total++; if (e[9] !== 1'b0)     $display("FAIL basic_oframe got %b exp 0", e[9]);        else passed++;
        // stop-bit midpoint is 152 clocks after the start edge, plus synchroniser delay
        total++; if (rise1 - s < 150 || rise1 - s > 165)
            $display("FAIL basic_latency got %0d exp 150..165", rise1 - s); else passed++;
    endtask

    task automatic test_glitch;
        int b0;
        logic [9:0] e;
        b0 = beats1;
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(40);
        total++; if (beats1 !== b0) $display("FAIL glitch_no_beat got %0d exp 0", beats1 - b0); else passed++;
        total++; if (ovalid !== 1'b0) $display("FAIL glitch_ovalid got %b exp 0", ovalid); else passed++;
        send({1'b0, 8'h55}, 8, 1'b0);
        tick(20);
        e = log1[b0 % 64];
        total++; if (beats1 - b0 !== 1) $display("FAIL glitch_after_beats got %0d exp 1", beats1 - b0); else passed++;
        total++; if (e[7:0] !== 8'h55)  $display("FAIL glitch_after_data got %h exp 55", e[7:0]);      else passed++;
        total++; if (e[9] !== 1'b0)     $display("FAIL glitch_after_oframe got %b exp 0", e[9]);       else passed++;
    endtask

    task automatic test_break;
        int b0;
        logic [9:0] e;
        b0 = beats1;
        rxd = 1'b0;
        tick(20 * 16);
        rxd = 1'b1;
        tick(40);
        e = log1[b0 % 64];
        total++; if (beats1 - b0 !== 1) $display("FAIL break_beats got %0d exp 1", beats1 - b0); else passed++;
        total++; if (e[7:0] !== 8'h00)  $display("FAIL break_data got %h exp 00", e[7:0]);      else passed++;
        total++; if (e[9] !== 1'b1)     $display("FAIL break_oframe got %b exp 1", e[9]);        else passed++;
        total++; if (e[8] !== 1'b0)     $display("FAIL break_operror got %b exp 0", e[8]);       else passed++;
        send({1'b0, 8'h0F}, 8, 1'b0);
        tick(20);
        e = log1[(b0 + 1) % 64];
        total++; if (beats1 - b0 !== 2) $display("FAIL break_next_beats got %0d exp 2", beats1 - b0); else passed++;
        total++; if (e[7:0] !== 8'h0F)  $display("FAIL break_next_data got %h exp 0f", e[7:0]);      else passed++;
        total++; if (e[9] !== 1'b0)     $display("FAIL break_next_oframe got %b exp 0", e[9]);       else passed++;
    endtask

    task automatic test_overflow;
        oready = 1'b0;
        send({1'b0, 8'h11}, 8, 1'b0);
        tick(20);
        total++; if (ovalid !== 1'b1)   $display("FAIL ovf_first_ovalid got %b exp 1", ovalid);     else passed++;
        total++; if (odata !== 8'h11)   $display("FAIL ovf_first_data got %h exp 11", odata);       else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_first_overflow got %b exp 0", overflow); else passed++;
        total++; if (rtsn_pin !== 1'b1) $display("FAIL ovf_first_rtsn got %b exp 1", rtsn_pin);     else passed++;
        send({1'b0, 8'h22}, 8, 1'b0);
        tick(20);
        total++; if (odata !== 8'h11)   $display("FAIL ovf_held_data got %h exp 11", odata);        else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", overflow);           else passed++;
        total++; if (ovalid !== 1'b1)   $display("FAIL ovf_held_ovalid got %b exp 1", ovalid);      else passed++;
    endtask

    task automatic test_reset_midframe;
        int b0;
        logic [7:0] d;
        logic [9:0] e;
        b0 = beats1;
        d  = 8'h5A;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i], 1'b0);
        rxd = d[4];
        tick(8);
        resetn = 1'b0;
        tick(2);
        total++; if (ovalid !== 1'b0)   $display("FAIL rstmid_ovalid got %b exp 0", ovalid);     else passed++;
        total++; if (operror !== 1'b0)  $display("FAIL rstmid_operror got %b exp 0", operror);   else passed++;
        total++; if (oframe !== 1'b0)   $display("FAIL rstmid_oframe got %b exp 0", oframe);     else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL rstmid_overflow got %b exp 0", overflow); else passed++;
        total++; if (rtsn_pin !== 1'b1) $display("FAIL rstmid_rtsn got %b exp 1", rtsn_pin);     else passed++;
        rxd = 1'b1;
        tick(2);
        resetn = 1'b1;
        oready = 1'b1;
        tick(200);
        total++; if (beats1 !== b0)   $display("FAIL rstmid_no_beat got %0d exp 0", beats1 - b0); else passed++;
        total++; if (ovalid !== 1'b0) $display("FAIL rstmid_after_ovalid got %b exp 0", ovalid);  else passed++;
        send({1'b0, 8'hC3}, 8, 1'b0);
        tick(20);
        e = log1[b0 % 64];
        total++; if (beats1 - b0 !== 1) $display("FAIL rstmid_next_beats got %0d exp 1", beats1 - b0); else passed++;
        total++; if (e[7:0] !== 8'hC3)  $display("FAIL rstmid_next_data got %h exp c3", e[7:0]);      else passed++;
        total++; if (e[9:8] !== 2'b00)  $display("FAIL rstmid_next_flags got %b exp 00", e[9:8]);     else passed++;
    endtask

    task automatic test_back_to_back;
        int b0;
        logic [9:0] e;
        oready = 1'b0;
        b0 = beats1;
        send({1'b0, 8'h11}, 8, 1'b0);
        tick(20);
        // release the held beat in the cycle the 0x22 frame completes (stop sample)
        fork
            send({1'b0, 8'h22}, 8, 1'b0);
            begin
                tick(156);
                oready = 1'b1;
            end
        join
        tick(20);
        total++; if (overflow !== 1'b0) $display("FAIL b2b_overflow got %b exp 0", overflow); else passed++;
        total++; if (beats1 - b0 !== 2) $display("FAIL b2b_beats got %0d exp 2", beats1 - b0); else passed++;
        e = log1[b0 % 64];
        total++; if (e[7:0] !== 8'h11) $display("FAIL b2b_first got %h exp 11", e[7:0]); else passed++;
        e = log1[(b0 + 1) % 64];
        total++; if (e[7:0] !== 8'h22) $display("FAIL b2b_second got %h exp 22", e[7:0]); else passed++;
        total++; if (ovalid !== 1'b0)  $display("FAIL b2b_ovalid got %b exp 0", ovalid);  else passed++;
    endtask

    task automatic test_parity;
        int b0;
        logic [9:0] e;
        oready2 = 1'b1;
        b0 = beats2;
        // 0x37 has five ones, so the even-parity bit is 1
        send({1'b1, 8'h37}, 9, 1'b1);
        tick(20);
        e = log2[b0 % 64];
        total++; if (beats2 - b0 !== 1) $display("FAIL par_good_beats got %0d exp 1", beats2 - b0); else passed++;
        total++; if (e[8] !== 1'b0)     $display("FAIL par_good_operror got %b exp 0", e[8]);      else passed++;
        total++; if (e[7:0] !== 8'h37)  $display("FAIL par_good_data got %h exp 37", e[7:0]);      else passed++;
        send({1'b0, 8'h37}, 9, 1'b1);
        tick(20);
        e = log2[(b0 + 1) % 64];
        total++; if (beats2 - b0 !== 2) $display("FAIL par_bad_beats got %0d exp 2", beats2 - b0); else passed++;
        total++; if (e[8] !== 1'b1)     $display("FAIL par_bad_operror got %b exp 1", e[8]);       else passed++;
        total++; if (e[7:0] !== 8'h37)  $display("FAIL par_bad_data got %h exp 37", e[7:0]);       else passed++;
        total++; if (e[9] !== 1'b0)     $display("FAIL par_bad_oframe got %b exp 0", e[9]);        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
        test_parity();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
